sram_bank_controller: RTL and testbench
=======================================

SRAM_BANK_CONTROLLER -- requirements
Module: sram_bank_controller

Interface
REQ-001 Parameter BANKS, default 2, number of SRAM banks, legal range 1..8.
REQ-002 Parameter WE_CYCLES, default 3, write-strobe width in i_CLK cycles, legal range 1..15.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 i_CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 i_RST  input  1  synchronous active-high reset.
REQ-006 i_CS  input  BANKS  bank select from address decoder, active-high, expected one-hot; asynchronous to i_CLK.
REQ-007 i_RW  input  1  CPU read/write: 1 = read, 0 = write; asynchronous to i_CLK.
REQ-008 i_E  input  1  CPU bus strobe, active-high; asynchronous to i_CLK.
REQ-009 o_CE  output  BANKS  per-bank chip enable, active-low.
REQ-010 o_CE2  output  1  shared secondary chip enable, active-high.
REQ-011 o_WE  output  1  SRAM write enable, active-low.
REQ-012 o_RE  output  1  SRAM output enable, active-low.
REQ-013 o_BUSY  output  1  high whenever the state is not IDLE.
REQ-014 o_ERR  output  1  one-clock pulse on a bus-protocol error.

Function
REQ-015 i_E, i_RW and i_CS SHALL each pass through a 2-flop synchronizer; all decisions use synchronized values only.
REQ-016 e_rise/e_fall SHALL be detected by comparing synchronized E against its previous registered value.
REQ-017 States SHALL be IDLE, READ, WRITE and HOLD.
REQ-018 Every output SHALL be registered and updated on the same edge as the state register.
REQ-019 IDLE, e_rise with exactly one synchronized CS bit set: latch the bank index; go to READ if RW=1, else WRITE.
REQ-020 IDLE, e_rise with no CS bit set: stay in IDLE, no output change.
REQ-021 IDLE, e_rise with more than one CS bit set: stay in IDLE and pulse o_ERR for one cycle.
REQ-022 Latency: outputs SHALL assert on the 3rd rising edge of i_CLK, counting the first edge that samples i_E high as edge 1.
REQ-023 READ: drive o_CE[bank]=0, o_RE=0, o_CE2=1; on e_fall go to IDLE, deasserting all of these on that edge.
REQ-024 WRITE: drive o_CE[bank]=0, o_WE=0, o_CE2=1 for exactly WE_CYCLES cycles using a 4-bit counter, then go to HOLD.
REQ-025 HOLD: o_WE=1, o_CE[bank]=0 and o_CE2=1 are held; on e_fall go to IDLE and deassert everything.
REQ-026 e_fall during WRITE before the counter expires: abort to IDLE, deassert all strobes and pulse o_ERR (short write).
REQ-027 o_WE and o_RE SHALL never be low simultaneously.
REQ-028 At most one o_CE bit SHALL be low at any time.
REQ-029 Changes to i_CS or i_RW during a cycle SHALL be ignored until the next IDLE e_rise.
REQ-030 When the e_fall and e_rise that start the next cycle are separated by one synchronized sample, the next cycle SHALL be accepted from IDLE normally.

Reset
REQ-031 While i_RST=1 at a clock edge: o_CE all 1s, o_WE=1, o_RE=1, o_CE2=0, o_BUSY=0, o_ERR=0.
REQ-032 On such an edge, state=IDLE, counter=0, and all synchronizer and edge flops are cleared to 0.
REQ-033 Reset asserted mid-cycle SHALL deassert all strobes on that same edge, with no o_ERR pulse.
REQ-034 After reset release, a strobe already high SHALL NOT start a cycle until E has been seen low and rises again.

Configuration
REQ-035 Macro SRAM_WRITE_PROTECT_EN, when defined, SHALL add input port i_WP, width BANKS, active-high per-bank write protect, synchronized like i_CS.
REQ-036 With SRAM_WRITE_PROTECT_EN defined, a write to a protected bank SHALL follow WRITE/HOLD timing with o_WE held at 1, o_CE and o_CE2 asserted, and o_ERR pulsed on entry to WRITE.
REQ-037 Without SRAM_WRITE_PROTECT_EN, the i_WP port SHALL be absent and all writes SHALL proceed.

Verification
REQ-038 BANKS=2, CS=01, RW=1, E high for 10 clocks -> o_CE=10 and o_RE=0 from the 3rd edge; released 3 edges after E falls; o_WE stays 1.
REQ-039 CS=10, RW=0, WE_CYCLES=3, E high for 10 clocks -> o_CE=01; o_WE low for exactly 3 clocks; HOLD until e_fall; o_BUSY tracks the cycle.
REQ-040 CS=11, E pulse -> no CE, WE or RE activity; o_ERR high for exactly 1 clock.
REQ-041 RW=0, WE_CYCLES=15, E high for only 6 clocks -> o_WE aborts at e_fall, o_ERR pulses, state returns to IDLE.
REQ-042 i_RST asserted for 1 clock during WRITE -> all strobes deasserted at that edge; no new cycle starts while E remains high.
REQ-043 SRAM_WRITE_PROTECT_EN defined, i_WP=01, write to bank 0 -> o_CE[0]=0, o_WE stays 1, o_ERR pulses once.

Source files
------------

// File: rtl/sram_bank_controller.sv
// sram_bank_controller: async CPU strobe to per-bank SRAM CE/WE/RE sequencer.
// Optional write protect input i_WP when SRAM_WRITE_PROTECT_EN is defined.
module sram_bank_controller #(
    parameter int BANKS     = 2,
    parameter int WE_CYCLES = 3
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [BANKS-1:0] i_CS,
    input  logic             i_RW,
    input  logic             i_E,
`ifdef SRAM_WRITE_PROTECT_EN
    input  logic [BANKS-1:0] i_WP,
`endif
    output logic [BANKS-1:0] o_CE,
    output logic             o_CE2,
    output logic             o_WE,
    output logic             o_RE,
    output logic             o_BUSY,
    output logic             o_ERR
);

    localparam int IW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam logic [3:0] WE_LAST = 4'(WE_CYCLES);

    typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} state_t;

    logic             e_m, e_s, e_prev;
    logic             rw_m, rw_s;
    logic [BANKS-1:0] cs_m, cs_s;
    logic [1:0]       fill_q;
    logic             armed_q;
    logic             e_rise, e_fall;

    state_t           state_q, state_n;
    logic [3:0]       cnt_q, cnt_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic             prot_q, prot_n;

    logic [3:0]       cs_cnt;
    logic [IW-1:0]    cs_idx;
    logic             wp_hit;

    logic [BANKS-1:0] ce_n;
    logic             ce2_n, we_n, re_n, busy_n, err_n;

    // A strobe left high across reset must be seen low before it can
    // start a cycle, so arming waits for a real synchronized low sample.
    assign e_rise = e_s & ~e_prev & armed_q;
    assign e_fall = ~e_s & e_prev;

    // Two-flop synchronizers, edge history and post-reset arming.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            e_m     <= 1'b0;
            e_s     <= 1'b0;
            e_prev  <= 1'b0;
            rw_m    <= 1'b0;
            rw_s    <= 1'b0;
            cs_m    <= '0;
            cs_s    <= '0;
            fill_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            e_m     <= i_E;
            e_s     <= e_m;
            e_prev  <= e_s;
            rw_m    <= i_RW;
            rw_s    <= rw_m;
            cs_m    <= i_CS;
            cs_s    <= cs_m;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_q | (fill_q[1] & ~e_s);
        end
    end

`ifdef SRAM_WRITE_PROTECT_EN
    logic [BANKS-1:0] wp_m, wp_s;

    // Write-protect synchronizer, same depth as the bank select.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            wp_m <= '0;
            wp_s <= '0;
        end else begin
            wp_m <= i_WP;
            wp_s <= wp_m;
        end
    end
`endif

    // Decode select population and index, next state and next outputs.
    always_comb begin
        cs_cnt = '0;
        cs_idx = '0;
        wp_hit = 1'b0;
        for (int i = 0; i < BANKS; i++) begin
            if (cs_s[i]) begin
                cs_cnt = cs_cnt + 4'd1;
                cs_idx = IW'(i);
            end
`ifdef SRAM_WRITE_PROTECT_EN
            wp_hit = wp_hit | (cs_s[i] & wp_s[i]);
`endif
        end

        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        prot_n  = prot_q;
        err_n   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (e_rise) begin
                    if (cs_cnt == 4'd1) begin
                        idx_n = cs_idx;
                        if (rw_s) begin
                            state_n = READ;
                        end else begin
                            state_n = WRITE;
                            cnt_n   = 4'd1;
                            prot_n  = wp_hit;
                            err_n   = wp_hit;
                        end
                    end else if (cs_cnt > 4'd1) begin
                        err_n = 1'b1;
                    end
                end
            end
            READ: begin
                if (e_fall) state_n = IDLE;
            end
            WRITE: begin
                if (cnt_q == WE_LAST) begin
                    state_n = e_fall ? IDLE : HOLD;
                    cnt_n   = '0;
                end else if (e_fall) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    err_n   = 1'b1;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (e_fall) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        ce_n   = '1;
        ce2_n  = 1'b0;
        we_n   = 1'b1;
        re_n   = 1'b1;
        busy_n = (state_n != IDLE);
        if (state_n != IDLE) begin
            ce2_n = 1'b1;
            for (int i = 0; i < BANKS; i++) begin
                if (IW'(i) == idx_n) ce_n[i] = 1'b0;
            end
        end
        if (state_n == READ) re_n = 1'b0;
        if (state_n == WRITE && !prot_n) we_n = 1'b0;
    end

    // State, counter and every output register update on one edge.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            prot_q  <= 1'b0;
            o_CE    <= '1;
            o_CE2   <= 1'b0;
            o_WE    <= 1'b1;
            o_RE    <= 1'b1;
            o_BUSY  <= 1'b0;
            o_ERR   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            prot_q  <= prot_n;
            o_CE    <= ce_n;
            o_CE2   <= ce2_n;
            o_WE    <= we_n;
            o_RE    <= re_n;
            o_BUSY  <= busy_n;
            o_ERR   <= err_n;
        end
    end

endmodule

// File: tb/tb_sram_bank_controller.sv
// tb_sram_bank_controller: directed bus cycles with a timed output scoreboard.
// Write protect case runs only when SRAM_WRITE_PROTECT_EN is defined.
module tb_sram_bank_controller;

    logic       i_CLK = 1'b0;
    logic       i_RST;
    logic [1:0] i_CS;
    logic       i_RW;
    logic       i_E;
`ifdef SRAM_WRITE_PROTECT_EN
    logic [1:0] i_WP;
`endif
    logic [1:0] o_CE;
    logic       o_CE2, o_WE, o_RE, o_BUSY, o_ERR;

    sram_bank_controller #(
        .BANKS(2),
        .WE_CYCLES(3)
    ) u_dut (
        .i_CLK (i_CLK),
        .i_RST (i_RST),
        .i_CS  (i_CS),
        .i_RW  (i_RW),
        .i_E   (i_E),
`ifdef SRAM_WRITE_PROTECT_EN
        .i_WP  (i_WP),
`endif
        .o_CE  (o_CE),
        .o_CE2 (o_CE2),
        .o_WE  (o_WE),
        .o_RE  (o_RE),
        .o_BUSY(o_BUSY),
        .o_ERR (o_ERR)
    );

    always #5 i_CLK = ~i_CLK;

    // bundle = {CE[1:0], CE2, WE, RE, BUSY, ERR}
    localparam logic [6:0] IDLE_B = 7'b11_0_1_1_0_0;
    localparam logic [6:0] ERR_B  = 7'b11_0_1_1_0_1;
    localparam logic [6:0] RD0    = 7'b10_1_1_0_1_0;
    localparam logic [6:0] RD1    = 7'b01_1_1_0_1_0;
    localparam logic [6:0] WR0    = 7'b10_1_0_1_1_0;
    localparam logic [6:0] WR1    = 7'b01_1_0_1_1_0;
    localparam logic [6:0] HD0    = 7'b10_1_1_1_1_0;
    localparam logic [6:0] HD1    = 7'b01_1_1_1_1_0;
    localparam logic [6:0] WP0    = 7'b10_1_1_1_1_1;

    typedef struct {
        logic [6:0] val;
        int         cyc;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   base   = 0;
    int   total  = 0;
    int   bad    = 0;
    logic mon_en = 1'b0;

    always @(posedge i_CLK) cyc <= cyc + 1;

    function automatic logic [6:0] bundle();
        return {o_CE, o_CE2, o_WE, o_RE, o_BUSY, o_ERR};
    endfunction

    task automatic ex(input int off, input logic [6:0] v, input string tag);
        exp_t e;
        e.val = v;
        e.cyc = base + off;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic begin_txn();
        repeat (6) @(negedge i_CLK);
        base = cyc;
    endtask

    task automatic drive(input logic [1:0] cs, input logic rw, input int h);
        i_CS = cs;
        i_RW = rw;
        i_E  = 1'b1;
        repeat (h) @(negedge i_CLK);
        i_E = 1'b0;
    endtask

    // Monitor: each output change pops one expectation; invariants every cycle.
    initial begin
        logic [6:0] prev, cur;
        exp_t       e;
        wait (mon_en);
        prev = bundle();
        forever begin
            @(negedge i_CLK);
            cur = bundle();
            total++;
            if (!o_WE && !o_RE) begin
                bad++;
                $display("FAIL we_re_overlap got WE=%b RE=%b need not both 0 cyc=%0d",
                         o_WE, o_RE, cyc);
            end
            total++;
            if ($countones(~o_CE) > 1) begin
                bad++;
                $display("FAIL ce_multi got CE=%b need at most one low cyc=%0d",
                         o_CE, cyc);
            end
            if (cur !== prev) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected got=%b from=%b cyc=%0d need no change",
                             cur, prev, cyc);
                end else begin
                    e = sbq.pop_front();
                    if (cur !== e.val || cyc != e.cyc) begin
                        bad++;
                        $display("FAIL %s got=%b at cyc %0d need=%b at cyc %0d",
                                 e.tag, cur, cyc, e.val, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        int guard;
        i_RST = 1'b1;
        i_E   = 1'b0;
        i_CS  = 2'b00;
        i_RW  = 1'b1;
`ifdef SRAM_WRITE_PROTECT_EN
        i_WP  = 2'b00;
`endif
        repeat (3) @(negedge i_CLK);
        total++;
        if (bundle() !== IDLE_B) begin
            bad++;
            $display("FAIL reset_state got=%b need=%b", bundle(), IDLE_B);
        end
        i_RST = 1'b0;
        repeat (4) @(negedge i_CLK);
        mon_en = 1'b1;

        // read bank 0; CS/RW wiggle mid-cycle is ignored
        begin_txn();
        ex(3, RD0, "rd0_on");
        ex(13, IDLE_B, "rd0_off");
        i_CS = 2'b01;
        i_RW = 1'b1;
        i_E  = 1'b1;
        repeat (5) @(negedge i_CLK);
        i_CS = 2'b10;
        i_RW = 1'b0;
        repeat (5) @(negedge i_CLK);
        i_E = 1'b0;

        // write bank 1, three WE cycles then hold
        begin_txn();
        ex(3, WR1, "wr1_on");
        ex(6, HD1, "wr1_hold");
        ex(13, IDLE_B, "wr1_off");
        drive(2'b10, 1'b0, 10);

        // two selects: error pulse only
        begin_txn();
        ex(3, ERR_B, "multi_cs_err");
        ex(4, IDLE_B, "multi_cs_clr");
        drive(2'b11, 1'b1, 4);

        // no select: nothing moves
        begin_txn();
        drive(2'b00, 1'b1, 4);

        // short write aborted
        begin_txn();
        ex(3, WR0, "short_on");
        ex(5, ERR_B, "short_abort");
        ex(6, IDLE_B, "short_clr");
        drive(2'b01, 1'b0, 2);

        // fall exactly as counter expires: completes, no error
        begin_txn();
        ex(3, WR1, "exact_on");
        ex(6, IDLE_B, "exact_off");
        drive(2'b10, 1'b0, 3);

        // back-to-back with a single low sample between cycles
        begin_txn();
        ex(3, RD0, "b2b_a_on");
        ex(9, IDLE_B, "b2b_a_off");
        ex(10, RD1, "b2b_b_on");
        ex(15, IDLE_B, "b2b_b_off");
        drive(2'b01, 1'b1, 6);
        @(negedge i_CLK);
        drive(2'b10, 1'b1, 5);

        // reset mid-write, strobe kept high must not restart
        begin_txn();
        ex(3, WR0, "rst_wr_on");
        ex(5, IDLE_B, "rst_wr_kill");
        i_CS = 2'b01;
        i_RW = 1'b0;
        i_E  = 1'b1;
        repeat (4) @(negedge i_CLK);
        i_RST = 1'b1;
        @(negedge i_CLK);
        i_RST = 1'b0;
        repeat (8) @(negedge i_CLK);
        i_E = 1'b0;

        // recovery read after reset
        begin_txn();
        ex(3, RD1, "recover_on");
        ex(8, IDLE_B, "recover_off");
        drive(2'b10, 1'b1, 5);

`ifdef SRAM_WRITE_PROTECT_EN
        // protected write to bank 0
        i_WP = 2'b01;
        begin_txn();
        ex(3, WP0, "wp_on");
        ex(4, HD0, "wp_err_clr");
        ex(11, IDLE_B, "wp_off");
        drive(2'b01, 1'b0, 8);
`endif

        guard = 0;
        while (sbq.size() != 0 && guard < 100) begin
            @(negedge i_CLK);
            guard++;
        end
        repeat (5) @(negedge i_CLK);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL pending got=%0d outstanding need=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
